// File: rtl/siso_prbs_tester_pkg.sv
// Shared constants and helpers for the SISO PRBS tester and its checker.
// Helpers work on a fixed maximum width; callers zero-extend and truncate.
package siso_prbs_tester_pkg;

    localparam int unsigned MAX_W = 32;

    // Maximal-length feedback masks (bit k set = state bit k tapped)
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [4:0]  TAPS_W5  = 5'h14;

    // Johnson step for a w-bit counter held in the low bits of j
    function automatic logic [MAX_W-1:0] johnson_next(input logic [MAX_W-1:0] j,
                                                      input int unsigned w);
        logic [MAX_W-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w) mask[i] = 1'b1;
        end
        return {j[MAX_W-2:0], ~j[w-1]} & mask;
    endfunction

    function automatic logic lfsr_fb(input logic [MAX_W-1:0] state,
                                     input logic [MAX_W-1:0] taps);
        return ^(state & taps);
    endfunction

endpackage

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: predicts each incoming bit from the last
// W received bits, tracks a match run for lock, and counts errors while locked.
module prbs_checker
    import siso_prbs_tester_pkg::*;
#(
    parameter int unsigned  W        = 8,
    parameter logic [W-1:0] TAPS     = TAPS_W8,
    parameter int unsigned  LOCK_RUN = 16,
    parameter int unsigned  ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                step,
    input  logic                din,
    output logic                locked,
    output logic                err_pulse,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int unsigned       RUN_W    = $clog2(LOCK_RUN + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(LOCK_RUN);
    localparam logic [MAX_W-1:0]  TAPS_EXT = MAX_W'(TAPS);

    logic [W-1:0]        c_q, c_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic                locked_q, locked_d;
    logic                err_pulse_q, err_pulse_d;
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;
    logic                predicted;

    assign predicted = lfsr_fb(MAX_W'(c_q), TAPS_EXT);

    always_comb begin
        c_d         = c_q;
        run_d       = run_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        if (step) begin
            // History always shifts, even on a mismatch, so the checker resyncs
            c_d = {c_q[W-2:0], din};
            if (c_q == '0) begin
                run_d = '0;
            end else if (predicted == din) begin
                if (run_q != RUN_MAX) run_d = run_q + 1'b1;
                if (run_d == RUN_MAX) locked_d = 1'b1;
            end else begin
                run_d    = '0;
                locked_d = 1'b0;
                if (locked_q) begin
                    err_pulse_d = 1'b1;
                    if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q         <= '0;
            run_q       <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            c_q         <= c_d;
            run_q       <= run_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule

// File: rtl/siso_prbs_tester.sv
// LFSR pattern source, Johnson-paced stepping, SISO delay line and a PRBS
// checker on the delay-line output.
module siso_prbs_tester
    import siso_prbs_tester_pkg::*;
#(
    parameter int unsigned       LFSR_W    = 8,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = TAPS_W8,
    parameter int unsigned       DEPTH     = 16,
    parameter int unsigned       JOHNSON_W = 4,
    parameter int unsigned       ERRCNT_W  = 8,
    parameter int unsigned       LOCK_RUN  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lfsr_en,
    input  logic                 slow,
    input  logic                 din_sel,
    input  logic                 d_in,
    input  logic                 seed_load,
    input  logic [LFSR_W-1:0]    seed,
    output logic                 d_out,
    output logic [JOHNSON_W-1:0] johnson,
    output logic                 lfsr_bit,
    output logic                 lfsr_period,
    output logic [LFSR_W-1:0]    lfsr_state,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERRCNT_W-1:0]  err_count
);

    localparam logic [MAX_W-1:0] TAPS_EXT = MAX_W'(LFSR_TAPS);

    logic [JOHNSON_W-1:0] johnson_q, johnson_d;
    logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
    logic                 in_q, in_d;
    logic [DEPTH-1:0]     sr_q, sr_d;
    logic                 step;

    // SLOW is not registered so a mode change applies in the same cycle
    assign step = slow ? (johnson_q == '0) : 1'b1;

    always_comb begin
        johnson_d = JOHNSON_W'(johnson_next(MAX_W'(johnson_q), JOHNSON_W));
    end

    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load) begin
            lfsr_d = (seed == '0) ? '1 : seed;
        end else if (lfsr_q == '0) begin
            lfsr_d = '1;
        end else if (step && lfsr_en) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_fb(MAX_W'(lfsr_q), TAPS_EXT)};
        end
    end

    always_comb begin
        in_d = in_q;
        sr_d = sr_q;
        if (step) begin
            in_d = din_sel ? lfsr_q[LFSR_W-1] : d_in;
            for (int i = int'(DEPTH) - 1; i > 0; i--) begin
                sr_d[i] = sr_q[i-1];
            end
            sr_d[0] = in_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            johnson_q <= '0;
            lfsr_q    <= '1;
            in_q      <= 1'b0;
            sr_q      <= '0;
        end else begin
            johnson_q <= johnson_d;
            lfsr_q    <= lfsr_d;
            in_q      <= in_d;
            sr_q      <= sr_d;
        end
    end

    prbs_checker #(
        .W        (LFSR_W),
        .TAPS     (LFSR_TAPS),
        .LOCK_RUN (LOCK_RUN),
        .ERRCNT_W (ERRCNT_W)
    ) u_checker (
        .clk       (clk),
        .rst_n     (rst_n),
        .step      (step),
        .din       (sr_q[DEPTH-1]),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    assign d_out       = sr_q[DEPTH-1];
    assign johnson     = johnson_q;
    assign lfsr_bit    = lfsr_q[LFSR_W-1];
    assign lfsr_period = (lfsr_q == '1);
    assign lfsr_state  = lfsr_q;

endmodule

// File: tb/tb_siso_prbs_tester.sv
// Bench for siso_prbs_tester: two instances (8-bit and 2-bit error counters)
// checked every cycle against a behavioural model, plus literal spot checks.
module tb_siso_prbs_tester;

    localparam int JW       = 4;
    localparam int DEPTH    = 16;
    localparam int LOCK_RUN = 16;
    localparam logic [7:0] TAPS = 8'hB8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       lfsr_en = 1'b1, slow = 1'b0, din_sel = 1'b1, d_in = 1'b0, seed_load = 1'b0;
    logic [7:0] seed = 8'h00;

    logic       d_out_a, d_out_b, bit_a, bit_b, per_a, per_b;
    logic       lock_a, lock_b, pulse_a, pulse_b;
    logic [3:0] john_a, john_b;
    logic [7:0] state_a, state_b, cnt_a;
    logic [1:0] cnt_b;

    always #5 clk = ~clk;

    siso_prbs_tester dut_a (
        .clk(clk), .rst_n(rst_n), .lfsr_en(lfsr_en), .slow(slow), .din_sel(din_sel),
        .d_in(d_in), .seed_load(seed_load), .seed(seed), .d_out(d_out_a), .johnson(john_a),
        .lfsr_bit(bit_a), .lfsr_period(per_a), .lfsr_state(state_a), .locked(lock_a),
        .err_pulse(pulse_a), .err_count(cnt_a)
    );

    siso_prbs_tester #(.ERRCNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .lfsr_en(lfsr_en), .slow(slow), .din_sel(din_sel),
        .d_in(d_in), .seed_load(seed_load), .seed(seed), .d_out(d_out_b), .johnson(john_b),
        .lfsr_bit(bit_b), .lfsr_period(per_b), .lfsr_state(state_b), .locked(lock_b),
        .err_pulse(pulse_b), .err_count(cnt_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_phase;
    logic [7:0] m_lfsr;
    bit         m_pipe[$];   // last DEPTH+1 sampled bits, oldest first
    logic [7:0] m_c;
    int         m_run;
    bit         m_locked, m_pulse;
    int         m_errs;

    function automatic logic [3:0] johnson_of(input int p);
        int v;
        if (p < JW) v = (1 << p) - 1;
        else v = (((1 << JW) - 1) << (p - JW)) & ((1 << JW) - 1);
        return v[3:0];
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_lfsr = 8'hFF;
        m_pipe.delete();
        for (int i = 0; i <= DEPTH; i++) m_pipe.push_back(1'b0);
        m_c = 8'h00;
        m_run = 0;
        m_locked = 1'b0;
        m_pulse = 1'b0;
        m_errs = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        bit st, dout, lbit;
        int pred;
        if (!rst_n) begin
            model_reset();
        end else begin
            st = !slow || (m_phase == 0);
            dout = m_pipe[0];
            lbit = m_lfsr[7];
            m_pulse = 1'b0;
            if (st) begin
                pred = $countones(m_c & TAPS) % 2;
                if (m_c == 8'h00) begin
                    m_run = 0;
                end else if (pred == int'(dout)) begin
                    m_run = (m_run < LOCK_RUN) ? m_run + 1 : LOCK_RUN;
                    if (m_run == LOCK_RUN) m_locked = 1'b1;
                end else begin
                    if (m_locked) begin
                        m_pulse = 1'b1;
                        m_errs++;
                    end
                    m_run = 0;
                    m_locked = 1'b0;
                end
                m_c = {m_c[6:0], dout};
                m_pipe.push_back(din_sel ? lbit : d_in);
                void'(m_pipe.pop_front());
            end
            if (seed_load) m_lfsr = (seed == 8'h00) ? 8'hFF : seed;
            else if (m_lfsr == 8'h00) m_lfsr = 8'hFF;
            else if (st && lfsr_en) m_lfsr = {m_lfsr[6:0], 1'($countones(m_lfsr & TAPS) % 2)};
            m_phase = (m_phase + 1) % (2 * JW);
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("d_out_a", 32'(d_out_a), 32'(m_pipe[0]));
            check("d_out_b", 32'(d_out_b), 32'(m_pipe[0]));
            check("johnson_a", 32'(john_a), 32'(johnson_of(m_phase)));
            check("johnson_b", 32'(john_b), 32'(johnson_of(m_phase)));
            check("lfsr_state", 32'(state_a), 32'(m_lfsr));
            check("lfsr_bit", 32'(bit_a), 32'(m_lfsr[7]));
            check("lfsr_period", 32'(per_a), 32'(m_lfsr == 8'hFF));
            check("locked_a", 32'(lock_a), 32'(m_locked));
            check("locked_b", 32'(lock_b), 32'(m_locked));
            check("err_pulse_a", 32'(pulse_a), 32'(m_pulse));
            check("err_pulse_b", 32'(pulse_b), 32'(m_pulse));
            check("err_count_a", 32'(cnt_a), 32'((m_errs > 255) ? 255 : m_errs));
            check("err_count_b", 32'(cnt_b), 32'((m_errs > 3) ? 3 : m_errs));
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] gen;
    logic [7:0] exp_seq[6];

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 32'(state_a), 32'h0000_00FF);
        check({tag, "_bit"}, 32'(bit_a), 32'd1);
        check({tag, "_period"}, 32'(per_a), 32'd1);
        check({tag, "_johnson"}, 32'(john_a), 32'd0);
        check({tag, "_dout"}, 32'(d_out_a), 32'd0);
        check({tag, "_locked"}, 32'(lock_a), 32'd0);
        check({tag, "_pulse"}, 32'(pulse_a), 32'd0);
        check({tag, "_cnt_a"}, 32'(cnt_a), 32'd0);
        check({tag, "_cnt_b"}, 32'(cnt_b), 32'd0);
    endtask

    // Drive the reference PRBS on d_in; flip bit i when flip period hits
    task automatic prbs_cycles(input int n, input int first_flip, input int period,
                               output int pulses);
        bit flip;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pulses += int'(pulse_a);
            flip = (i >= first_flip) && (((i - first_flip) % period) == 0);
            d_in = gen[7] ^ flip;
            gen = {gen[6:0], ^(gen & TAPS)};
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
    endtask

    initial begin : stim
        int cyc, first_lock, cnt, pulses;
        bit prev, found;
        exp_seq = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};

        // Power-on reset
        #2 rst_n = 1'b0;
        #1 check_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Free-running LFSR feeding the SISO path; sequence, period and lock
        cyc = 0;
        first_lock = -1;
        for (int i = 0; i < 6; i++) begin
            check("lfsr_seq", 32'(state_a), 32'(exp_seq[i]));
            @(negedge clk);
            cyc++;
        end
        while (!per_a && cyc < 400) begin
            if (lock_a && first_lock < 0) first_lock = cyc;
            @(negedge clk);
            cyc++;
        end
        check("lfsr_period_255", 32'(cyc), 32'd255);
        check("lock_within_41", 32'(first_lock >= 0 && first_lock <= 41), 32'd1);
        repeat (1000) @(negedge clk);
        check("no_err_1000", 32'(cnt_a), 32'd0);
        check("still_locked", 32'(lock_a), 32'd1);

        // Slow stepping: period between rising edges of lfsr_period
        slow = 1'b1;
        prev = per_a;
        found = 1'b0;
        for (int i = 0; i < 2100 && !found; i++) begin
            @(negedge clk);
            if (per_a && !prev) found = 1'b1;
            prev = per_a;
        end
        cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 2100 && !found; i++) begin
            @(negedge clk);
            cnt++;
            if (per_a && !prev) found = 1'b1;
            prev = per_a;
        end
        check("slow_period_2040", 32'(cnt), 32'd2040);
        for (int i = 0; i < 20 && per_a; i++) @(negedge clk);
        check("seed_pre_not_ff", 32'(per_a), 32'd0);
        seed = 8'h00;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        check("seed0_loads_ff", 32'(state_a), 32'h0000_00FF);

        // Mid-run async reset, then single-bit error on external PRBS
        repeat (13) @(negedge clk);
        async_reset();
        check_reset_vals("mid");
        @(negedge clk);
        rst_n = 1'b1;
        slow = 1'b0;
        din_sel = 1'b0;
        gen = 8'hFF;
        d_in = gen[7];
        gen = {gen[6:0], ^(gen & TAPS)};
        cnt = 0;
        while (!lock_a && cnt < 120) begin
            prbs_cycles(1, 1000, 1, pulses);
            cnt++;
        end
        check("ext_locked", 32'(lock_a), 32'd1);
        prbs_cycles(5, 1000, 1, pulses);
        prbs_cycles(60, 0, 1000, pulses);
        check("single_err_pulses", 32'(pulses), 32'd1);
        check("single_err_count", 32'(cnt_a), 32'd1);
        check("relocked", 32'(lock_a), 32'd1);

        // Periodic errors: narrow counter saturates at 3
        async_reset();
        @(negedge clk);
        rst_n = 1'b1;
        gen = 8'hFF;
        prbs_cycles(400, 80, 40, pulses);
        check("periodic_pulses", 32'(pulses), 32'd8);
        check("periodic_cnt_a", 32'(cnt_a), 32'd8);
        check("saturated_cnt_b", 32'(cnt_b), 32'd3);

        // Randomised mix of all controls
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i % 64 == 0) begin
                slow = ($urandom_range(0, 3) == 0);
                din_sel = $urandom_range(0, 1) != 0;
            end
            lfsr_en = ($urandom_range(0, 7) != 0);
            d_in = $urandom_range(0, 1) != 0;
            seed_load = ($urandom_range(0, 31) == 0);
            seed = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        end
        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/siso_prbs_tester.md
Name: siso_prbs_tester

Overview:
Parametrised successor of the 8-bit LFSR + SISO path. It contains:
- a configurable Fibonacci LFSR with seed load and lock-up recovery;
- a Johnson phase counter that optionally slows the stepping;
- a DEPTH-stage SISO delay line fed from D_IN or the LFSR;
- a self-synchronising PRBS checker on D_OUT with lock detection and an error counter.

It sits behind the clock mux and reset synchroniser at top level. Its outputs drive uo_out and uio_out.

Parameters:
LFSR_W, 8, LFSR width (>=3)
LFSR_TAPS, 8'hB8, feedback mask (bit k set = state bit k tapped); default gives period 255
DEPTH, 16, SISO stages after the input register (>=1)
JOHNSON_W, 4, Johnson counter width; 2*JOHNSON_W phases
ERRCNT_W, 8, error counter width
LOCK_RUN, 16, consecutive matches required for LOCKED (>=LFSR_W)

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous active-low reset, clears all state
LFSR_EN  in  1  LFSR advances on STEP when 1
SLOW  in  1  0: STEP every cycle; 1: STEP only when JOHNSON==0
DIN_SEL  in  1  SISO source: 0 = D_IN, 1 = LFSR_BIT
D_IN  in  1  external serial data
SEED_LOAD  in  1  load SEED into LFSR
SEED  in  LFSR_W  seed value
D_OUT  out  1  last SISO stage
JOHNSON  out  JOHNSON_W  Johnson counter state
LFSR_BIT  out  1  LFSR state[LFSR_W-1]
LFSR_PERIOD  out  1  high while LFSR state is all-ones
LFSR_STATE  out  LFSR_W  LFSR state
LOCKED  out  1  checker locked
ERR_PULSE  out  1  one-cycle error strobe
ERR_COUNT  out  ERRCNT_W  saturating error count

Behaviour:
- Reset values:
  - LFSR_STATE = all-ones, so LFSR_BIT=1 and LFSR_PERIOD=1.
  - JOHNSON=0, SISO register and all stages=0, D_OUT=0.
  - Checker register=0, run=0, LOCKED=0, ERR_PULSE=0, ERR_COUNT=0.
- Johnson counter:
  - Advances every cycle, independent of any enable.
  - Update: J <= {J[W-2:0], ~J[W-1]}.
  - Sequence for W=4: 0000,0001,0011,0111,1111,1110,1100,1000, then wraps.
- STEP = SLOW ? (JOHNSON==0) : 1. SLOW is sampled every cycle; a change takes effect the same cycle.
- LFSR:
  - fb = ^(state & LFSR_TAPS); next = {state[W-2:0], fb}.
  - Advances when STEP & LFSR_EN.
  - SEED_LOAD has priority and loads in any cycle, regardless of STEP. SEED==0 loads all-ones.
  - If state is ever 0, the next cycle forces all-ones.
  - LFSR_PERIOD is combinational, asserted when state == all-ones.
- SISO path:
  - On STEP, the input register captures (DIN_SEL ? LFSR_BIT : D_IN) and the DEPTH stages shift.
  - D_OUT equals the sampled bit DEPTH+1 STEPs later. Nothing moves on non-STEP cycles.
- Checker (advances on STEP only):
  - predicted = ^(C & LFSR_TAPS), where C is the LFSR_W-bit history of D_OUT and C[0] is the newest bit. The comparison uses C before the update.
  - C <= {C[W-2:0], D_OUT} on every STEP, including after a mismatch (self-synchronising).
  - If C==0: run <= 0 and no error. This covers the all-zero fill window.
  - Match with C!=0: run <= min(run+1, LOCK_RUN). LOCKED is registered, set when run reaches LOCK_RUN.
  - Mismatch with C!=0: run <= 0 and LOCKED <= 0. If LOCKED was 1, ERR_PULSE=1 for one cycle and ERR_COUNT increments, saturating at all-ones. Errors while unlocked are not counted.
- Reset mid-operation clears everything asynchronously. The first STEP after release uses reset values.
- A changing DIN_SEL is not resynchronised. A source switch appears at D_OUT DEPTH+1 STEPs later.

Decomposition:
- Shared package:
  - default LFSR_TAPS constants per width: 8'hB8, 16'hB400, 5'h14;
  - function johnson_next(J);
  - function lfsr_fb(state, taps).
- Sub-module prbs_checker (C register, run counter, LOCKED, ERR_PULSE, ERR_COUNT). It is reused later for the uio input path.

Test Plan:
1. Assert RESET mid-run -> all outputs at the reset values listed above, asynchronously, before the next CLK edge.
2. LFSR_EN=1, SLOW=0 after reset -> LFSR_STATE FF,FE,FC,F8,F0,E1,...; LFSR_PERIOD high again exactly 255 cycles later.
3. SLOW=1 -> JOHNSON cycles with period 8; LFSR advances only on JOHNSON==0, so the period is 2040 cycles. SEED_LOAD=1 with SEED=0 -> next LFSR_STATE=FF.
4. DIN_SEL=1, D_IN=X -> first LFSR bit appears at D_OUT after DEPTH+1=17 STEPs; LOCKED=1 within 17+8+16 STEPs; ERR_COUNT stays 0 for 1000 cycles.
5. DIN_SEL=0, bench drives the default PRBS on D_IN, then flips one bit after LOCKED -> exactly one ERR_PULSE and ERR_COUNT=1. LOCKED drops, then returns after LOCK_RUN clean STEPs once the flipped bit leaves C.
6. ERRCNT_W=2, bench injects a single-bit error every 40 STEPs -> ERR_COUNT saturates at 3.
